// File: rtl/vga_pixel_fetch.sv
// +----------------------------------------------------------------------------+
// | vga_pixel_fetch: scaled frame-buffer address generation, pixel return     |
// | path and vsync-aligned double-buffer base swapping.  Rev 1.0               |
// +----------------------------------------------------------------------------+
`default_nettype none

module vga_pixel_fetch #(
  parameter int VGA_MAX_H     = 1650 - 1,
  parameter int VGA_MAX_V     = 750 - 1,
  parameter int VGA_WIDTH     = 1280,
  parameter int VGA_HEIGHT    = 720,
  parameter int FB_WIDTH      = 320,
  parameter int SCALE_H_SHIFT = 2,
  parameter int SCALE_V_SHIFT = 2,
  parameter int ADDR_BITS     = 16,
  parameter int BPP           = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          count_h,
  input  logic [31:0]          count_v,
  input  logic [ADDR_BITS-1:0] fb_base_in,
  input  logic                 swap_req,
  output logic                 swap_ack,
  output logic                 frame_start,
  output logic [ADDR_BITS-1:0] fb_raddr,
  input  logic [BPP-1:0]       fb_rdata,
  output logic [BPP-1:0]       color_out
);

  localparam logic [31:0]          MAX_H   = 32'(VGA_MAX_H);
  localparam logic [31:0]          MAX_V   = 32'(VGA_MAX_V);
  localparam logic [31:0]          WIDTH   = 32'(VGA_WIDTH);
  localparam logic [31:0]          HEIGHT  = 32'(VGA_HEIGHT);
  localparam logic [31:0]          V_MASK  = 32'((1 << SCALE_V_SHIFT) - 1);
  localparam logic [ADDR_BITS-1:0] FB_STEP = ADDR_BITS'(FB_WIDTH);

  logic [ADDR_BITS-1:0] active_base_q,  active_base_d;
  logic [ADDR_BITS-1:0] pending_base_q, pending_base_d;
  logic                 pending_q,      pending_d;
  logic [ADDR_BITS-1:0] line_addr_q,    line_addr_d;
  logic [ADDR_BITS-1:0] fb_raddr_q,     fb_raddr_d;
  logic                 act1_q,         act1_d;
  logic                 act2_q,         act2_d;
  logic                 swap_ack_q,     swap_ack_d;
  logic                 frame_start_q,  frame_start_d;

  logic        line_end;
  logic        frame_end;
  logic        advance;
  logic        active_now;
  logic [31:0] v_next;

  always_comb begin
    line_end   = (count_h == MAX_H) && (count_v < MAX_V);
    frame_end  = (count_h == MAX_H) && (count_v == MAX_V);
    v_next     = count_v + 32'd1;
    advance    = line_end && ((v_next & V_MASK) == 32'd0) && (v_next < HEIGHT);
    active_now = (count_h < WIDTH) && (count_v < HEIGHT);
  end

  always_comb begin
    active_base_d  = active_base_q;
    pending_base_d = pending_base_q;
    pending_d      = pending_q;
    line_addr_d    = line_addr_q;

    if (frame_end) begin
      if (pending_q) begin
        active_base_d = pending_base_q;
        line_addr_d   = pending_base_q;
        pending_d     = 1'b0;
      end else begin
        line_addr_d   = active_base_q;
      end
    end else if (advance) begin
      line_addr_d = line_addr_q + FB_STEP;
    end

    // Evaluated after the frame-end update so a request on that cycle waits a frame.
    if (swap_req) begin
      pending_d      = 1'b1;
      pending_base_d = fb_base_in;
    end

    swap_ack_d    = frame_end && pending_q;
    frame_start_d = frame_end;
    fb_raddr_d    = line_addr_q + ADDR_BITS'(count_h >> SCALE_H_SHIFT);
    act1_d        = active_now;
    act2_d        = act1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_base_q  <= '0;
      pending_base_q <= '0;
      pending_q      <= 1'b0;
      line_addr_q    <= '0;
      fb_raddr_q     <= '0;
      act1_q         <= 1'b0;
      act2_q         <= 1'b0;
      swap_ack_q     <= 1'b0;
      frame_start_q  <= 1'b0;
    end else begin
      active_base_q  <= active_base_d;
      pending_base_q <= pending_base_d;
      pending_q      <= pending_d;
      line_addr_q    <= line_addr_d;
      fb_raddr_q     <= fb_raddr_d;
      act1_q         <= act1_d;
      act2_q         <= act2_d;
      swap_ack_q     <= swap_ack_d;
      frame_start_q  <= frame_start_d;
    end
  end

  // RAM data arrives in step with the second delay stage.
  assign color_out   = act2_q ? fb_rdata : '0;
  assign fb_raddr    = fb_raddr_q;
  assign swap_ack    = swap_ack_q;
  assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_fetch.sv
// +----------------------------------------------------------------------------+
// | tb_vga_pixel_fetch: randomized raster stimulus against a frame-level model. |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_vga_pixel_fetch;

  localparam int MAX_H = 1649;
  localparam int MAX_V = 749;
  localparam int W     = 1280;
  localparam int H     = 720;
  localparam int FBW   = 320;
  localparam int SH    = 2;
  localparam int SV    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] count_h, count_v;
  logic [15:0] fb_base_in;
  logic        swap_req;
  logic        swap_ack, frame_start;
  logic [15:0] fb_raddr;
  logic [7:0]  fb_rdata = 8'h00;
  logic [7:0]  color_out;

  int checks   = 0;
  int failures = 0;

  // Reference model state: frame base, pending request, lines stepped this frame.
  int          m_active = 0;
  int          m_pbase  = 0;
  bit          m_pend   = 0;
  int          m_adv    = 0;
  bit          p_act    = 0;
  logic [15:0] p_raddr  = 16'h0;
  bit          ram_mode = 0;

  always #5 clk = ~clk;

  vga_pixel_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .count_h    (count_h),
    .count_v    (count_v),
    .fb_base_in (fb_base_in),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .frame_start(frame_start),
    .fb_raddr   (fb_raddr),
    .fb_rdata   (fb_rdata),
    .color_out  (color_out)
  );

  function automatic logic [7:0] ram_fn(input logic [15:0] a);
    return ram_mode ? 8'hFF : a[7:0];
  endfunction

  always @(posedge clk) fb_rdata <= ram_fn(fb_raddr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int h, input int v, input bit swp, input logic [15:0] base,
                      input bit rst);
    logic [15:0] e_raddr;
    logic [7:0]  e_col;
    bit          e_fs, e_ack;
    count_h    = 32'(h);
    count_v    = 32'(v);
    swap_req   = swp;
    fb_base_in = base;
    reset      = rst;
    if (rst) begin
      m_active = 0; m_pbase = 0; m_pend = 0; m_adv = 0;
      e_raddr = 16'h0; e_col = 8'h0; e_fs = 0; e_ack = 0;
      p_act = 0; p_raddr = 16'h0;
    end else begin
      e_raddr = 16'(m_active + FBW * m_adv + (h >> SH));
      e_col   = p_act ? ram_fn(p_raddr) : 8'h00;
      e_fs    = 0;
      e_ack   = 0;
      if (h == MAX_H && v == MAX_V) begin
        e_fs  = 1;
        e_ack = m_pend;
        if (m_pend) begin
          m_active = m_pbase;
          m_pend   = 0;
        end
        m_adv = 0;
      end else if (h == MAX_H && v < MAX_V && ((v + 1) % (1 << SV)) == 0 && (v + 1) < H) begin
        m_adv++;
      end
      if (swp) begin
        m_pend  = 1;
        m_pbase = int'(base);
      end
      p_act   = (h < W) && (v < H);
      p_raddr = e_raddr;
    end
    @(posedge clk);
    #1;
    chk("fb_raddr",    32'(fb_raddr),    32'(e_raddr));
    chk("color_out",   32'(color_out),   32'(e_col));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("swap_ack",    32'(swap_ack),    32'(e_ack));
  endtask

  task automatic run_lines(input int v0, input int v1, input int n);
    for (int v = v0; v <= v1; v++) begin
      for (int k = 0; k < n; k++) begin
        int hv, vv;
        hv = int'($urandom_range(0, 1800));
        vv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(750, 900)) : v;
        step(hv, vv, 1'b0, 16'($urandom), 1'b0);
      end
      step(MAX_H, v, 1'b0, 16'($urandom), 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1; count_h = '0; count_v = '0; swap_req = 1'b0; fb_base_in = '0;
    step(0, 0, 1'b0, 16'h0, 1'b1);
    step(0, 0, 1'b0, 16'h0, 1'b1);

    // Horizontal scaling on line 0, with identity RAM data
    for (int h = 0; h < 8; h++) step(h, 0, 1'b0, 16'h0, 1'b0);
    step(8, 0, 1'b0, 16'h0, 1'b0);

    // Blanking with the RAM returning 0xFF
    ram_mode = 1;
    step(1280, 0, 1'b0, 16'h0, 1'b0);
    step(1300, 0, 1'b0, 16'h0, 1'b0);
    step(0, 720, 1'b0, 16'h0, 1'b0);
    step(5, 720, 1'b0, 16'h0, 1'b0);
    step(3, 0, 1'b0, 16'h0, 1'b0);
    step(4, 0, 1'b0, 16'h0, 1'b0);
    ram_mode = 0;

    // Out-of-range counts produce no events
    step(2000, 0, 1'b0, 16'h0, 1'b0);
    step(MAX_H, 800, 1'b0, 16'h0, 1'b0);
    step(1700, MAX_V, 1'b0, 16'h0, 1'b0);

    // Frame 1: vertical scaling and a single mid-frame swap
    run_lines(0, 3, 2);
    step(1279, 4, 1'b0, 16'h0, 1'b0);
    chk("line4_end_addr", 32'(fb_raddr), 32'd639);
    run_lines(4, 99, 2);
    step(100, 100, 1'b1, 16'h4000, 1'b0);
    run_lines(100, 718, 2);
    step(0, 719, 1'b0, 16'h0, 1'b0);
    chk("line719_addr", 32'(fb_raddr), 32'd57280);
    run_lines(719, 748, 2);
    step(MAX_H, MAX_V, 1'b0, 16'h0, 1'b0);
    step(0, 0, 1'b0, 16'h0, 1'b0);
    chk("swap_base", 32'(fb_raddr), 32'h4000);

    // Frame 2: merged requests, plus one on the frame-end cycle
    run_lines(0, 9, 2);
    step(10, 10, 1'b1, 16'h4000, 1'b0);
    run_lines(10, 299, 2);
    step(20, 300, 1'b1, 16'h8000, 1'b0);
    run_lines(300, 748, 2);
    step(MAX_H, MAX_V, 1'b1, 16'h1234, 1'b0);
    step(0, 0, 1'b0, 16'h0, 1'b0);
    chk("merge_base", 32'(fb_raddr), 32'h8000);

    // Frame 3: the frame-end request lands here
    run_lines(0, 748, 2);
    step(MAX_H, MAX_V, 1'b0, 16'h0, 1'b0);
    step(0, 0, 1'b0, 16'h0, 1'b0);
    chk("late_base", 32'(fb_raddr), 32'h1234);

    // Frame 4: reset mid-frame with a swap pending
    run_lines(0, 200, 2);
    step(50, 201, 1'b1, 16'h5555, 1'b0);
    step(60, 201, 1'b0, 16'h0, 1'b1);
    step(61, 201, 1'b0, 16'h0, 1'b1);
    run_lines(201, 748, 2);
    step(MAX_H, MAX_V, 1'b0, 16'h0, 1'b0);
    step(0, 0, 1'b0, 16'h0, 1'b0);
    chk("post_reset_base", 32'(fb_raddr), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
